cond_logic_mc: RTL and testbench

//  Conditional-execution stage downstream of the multicycle main control FSM.
//  - Holds the NZCV flag register and evaluates the 4-bit ARM condition field.
//  - Gates the FSM's RegW/MemW/Branch strobes into the architectural

---
 rtl/cond_logic_mc.sv | 99 +++++++++
 tb/tb_cond_logic_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_logic_mc.sv
// cond_logic_mc: conditional-execution stage behind the multicycle control FSM.
// Holds NZCV and evaluates the ARM condition field once per instruction, in the
// DECODE cycle. Gates the FSM write/branch strobes into the architectural enables
// and counts instructions whose condition failed.
module cond_logic_mc #(
   parameter int         CNT_W     = 16,
   parameter logic [3:0] FLAGS_RST = 4'b0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             IRWrite,
   input  logic             NextPC,
   input  logic             Branch,
   input  logic             RegW,
   input  logic             MemW,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       Flags,
   output logic             CondExR,
   output logic [CNT_W-1:0] SkipCnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [3:0] {
      C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
      C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
      C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
      C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
   } cond_e;

   logic dec_q;    // high during the DECODE cycle (cycle after FETCH)
   logic cond_ex;  // condition result against the current registered flags
   logic n, z, c, v;

   assign {n, z, c, v} = Flags;

   // Condition evaluation against registered flags; 1111 behaves like AL.
   always_comb begin
      cond_ex = 1'b1;
      case (cond_e'(Cond))
         C_EQ: cond_ex = z;
         C_NE: cond_ex = ~z;
         C_CS: cond_ex = c;
         C_CC: cond_ex = ~c;
         C_MI: cond_ex = n;
         C_PL: cond_ex = ~n;
         C_VS: cond_ex = v;
         C_VC: cond_ex = ~v;
         C_HI: cond_ex = c & ~z;
         C_LS: cond_ex = ~c | z;
         C_GE: cond_ex = (n == v);
         C_LT: cond_ex = (n != v);
         C_GT: cond_ex = ~z & (n == v);
         C_LE: cond_ex = z | (n != v);
         default: cond_ex = 1'b1;
      endcase
   end

   // Strobe gating is purely combinational so the FSM sees no extra latency.
   // CondExR clears asynchronously on reset, which forces the gated enables low.
   assign RegWrite = RegW & CondExR;
   assign MemWrite = MemW & CondExR;
   assign PCWrite  = NextPC | (Branch & CondExR);

   // DECODE marker: one cycle behind the FETCH strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) dec_q <= 1'b0;
      else       dec_q <= IRWrite;
   end

   // Latch the condition at the end of DECODE; back-to-back fetches re-latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      CondExR <= 1'b0;
      else if (dec_q) CondExR <= cond_ex;
   end

   // Flag halves update independently, gated by the already-latched condition,
   // so a write on the latching edge still uses the previous instruction's result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Flags <= FLAGS_RST;
      end else begin
         if (FlagW[1] & CondExR) Flags[3:2] <= ALUFlags[3:2];
         if (FlagW[0] & CondExR) Flags[1:0] <= ALUFlags[1:0];
      end
   end

   // Squashed-instruction counter, saturating rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                     SkipCnt <= '0;
      else if (dec_q && !cond_ex && SkipCnt != CNT_MAX) SkipCnt <= SkipCnt + 1'b1;
   end

endmodule

// File: tb/tb_cond_logic_mc.sv
// Directed bench for cond_logic_mc: one task per scenario, inline checks.
module tb_cond_logic_mc;

   logic       clk = 1'b0;
   logic       reset, reset2;
   logic [3:0] Cond, ALUFlags;
   logic [1:0] FlagW;
   logic       IRWrite, NextPC, Branch, RegW, MemW;

   logic        PCWrite, RegWrite, MemWrite, CondExR;
   logic [3:0]  Flags;
   logic [15:0] SkipCnt;

   logic       PCWrite2, RegWrite2, MemWrite2, CondExR2;
   logic [3:0] Flags2;
   logic [1:0] SkipCnt2;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   cond_logic_mc #(.CNT_W(16), .FLAGS_RST(4'b0000)) dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .IRWrite(IRWrite), .NextPC(NextPC), .Branch(Branch), .RegW(RegW), .MemW(MemW),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .Flags(Flags), .CondExR(CondExR), .SkipCnt(SkipCnt)
   );

   cond_logic_mc #(.CNT_W(2), .FLAGS_RST(4'b0000)) dut2 (
      .clk(clk), .reset(reset2), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
      .IRWrite(IRWrite), .NextPC(NextPC), .Branch(Branch), .RegW(RegW), .MemW(MemW),
      .PCWrite(PCWrite2), .RegWrite(RegWrite2), .MemWrite(MemWrite2),
      .Flags(Flags2), .CondExR(CondExR2), .SkipCnt(SkipCnt2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      IRWrite = 0; NextPC = 0; Branch = 0; RegW = 0; MemW = 0; FlagW = 2'b00;
   endtask

   // FETCH then DECODE with the given Cond; returns in the EXECUTE cycle.
   task automatic fetch(input logic [3:0] c);
      IRWrite = 1; NextPC = 1;
      tick();
      IRWrite = 0; NextPC = 0; Cond = c;
      tick();
   endtask

   // Load all four flags via an always-executed instruction.
   task automatic set_flags(input logic [3:0] f);
      fetch(4'hE);
      FlagW = 2'b11; ALUFlags = f;
      tick();
      FlagW = 2'b00;
   endtask

   task automatic test_reset();
      idle(); Cond = 4'h0; ALUFlags = 4'h0;
      reset = 1; reset2 = 1;
      tick(); tick();
      reset = 0; reset2 = 0;
      tick();
      vectors++;
      if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
      vectors++;
      if (CondExR !== 1'b0) begin errors++; $display("FAIL reset_condexr got=%b exp=0", CondExR); end
      vectors++;
      if (SkipCnt !== 16'd0) begin errors++; $display("FAIL reset_skip got=%0d exp=0", SkipCnt); end
      vectors++;
      if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin
         errors++; $display("FAIL reset_enables got=%b exp=000", {PCWrite, RegWrite, MemWrite});
      end
   endtask

   task automatic test_always();
      IRWrite = 1; NextPC = 1;
      #1;
      vectors++;
      if (PCWrite !== 1'b1) begin errors++; $display("FAIL fetch_pcwrite got=%b exp=1", PCWrite); end
      tick();
      IRWrite = 0; NextPC = 0; Cond = 4'hE;
      tick();
      RegW = 1;
      #1;
      vectors++;
      if (CondExR !== 1'b1) begin errors++; $display("FAIL al_condexr got=%b exp=1", CondExR); end
      vectors++;
      if (RegWrite !== 1'b1) begin errors++; $display("FAIL al_regwrite got=%b exp=1", RegWrite); end
      vectors++;
      if (SkipCnt !== 16'd0) begin errors++; $display("FAIL al_skip got=%0d exp=0", SkipCnt); end
      tick();
      idle();
   endtask

   task automatic test_cond_fail();
      set_flags(4'b0100);
      vectors++;
      if (Flags !== 4'b0100) begin errors++; $display("FAIL setz_flags got=%b exp=0100", Flags); end
      fetch(4'h1);
      RegW = 1; MemW = 1; Branch = 1;
      #1;
      vectors++;
      if ({RegWrite, MemWrite, PCWrite} !== 3'b000) begin
         errors++; $display("FAIL ne_gated got=%b exp=000", {RegWrite, MemWrite, PCWrite});
      end
      vectors++;
      if (SkipCnt !== 16'd1) begin errors++; $display("FAIL ne_skip got=%0d exp=1", SkipCnt); end
      tick();
      idle();
   endtask

   task automatic test_flag_halves();
      fetch(4'hE);
      FlagW = 2'b10; ALUFlags = 4'b1011;
      tick();
      vectors++;
      if (Flags !== 4'b1000) begin errors++; $display("FAIL flagw10 got=%b exp=1000", Flags); end
      FlagW = 2'b01; ALUFlags = 4'b0110;
      tick();
      vectors++;
      if (Flags !== 4'b1010) begin errors++; $display("FAIL flagw01 got=%b exp=1010", Flags); end
      FlagW = 2'b11; ALUFlags = 4'b1011;
      tick();
      vectors++;
      if (Flags !== 4'b1011) begin errors++; $display("FAIL flagw11 got=%b exp=1011", Flags); end
      idle();
   endtask

   task automatic test_gt();
      set_flags(4'b1001);
      fetch(4'hC);
      vectors++;
      if (CondExR !== 1'b1) begin errors++; $display("FAIL gt_pass got=%b exp=1", CondExR); end
      set_flags(4'b1101);
      fetch(4'hC);
      vectors++;
      if (CondExR !== 1'b0) begin errors++; $display("FAIL gt_fail got=%b exp=0", CondExR); end
      vectors++;
      if (SkipCnt !== 16'd2) begin errors++; $display("FAIL gt_skip got=%0d exp=2", SkipCnt); end
      // A squashed instruction cannot write flags.
      FlagW = 2'b11; ALUFlags = 4'b0000;
      tick();
      vectors++;
      if (Flags !== 4'b1101) begin errors++; $display("FAIL squashed_flagw got=%b exp=1101", Flags); end
      idle();
   endtask

   task automatic test_same_edge();
      // CondExR is 0 here; a flag write on the latching edge uses that old value.
      IRWrite = 1;
      tick();
      IRWrite = 0; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0000;
      tick();
      FlagW = 2'b00;
      vectors++;
      if (Flags !== 4'b1101) begin errors++; $display("FAIL same_edge_flags got=%b exp=1101", Flags); end
      vectors++;
      if (CondExR !== 1'b1) begin errors++; $display("FAIL same_edge_condexr got=%b exp=1", CondExR); end
      idle();
   endtask

   task automatic test_back_to_back();
      // Flags Z=1: EQ passes, NE fails; the later decode decides CondExR.
      IRWrite = 1;
      tick();
      Cond = 4'h0;
      tick();
      IRWrite = 0; Cond = 4'h1;
      tick();
      vectors++;
      if (CondExR !== 1'b0) begin errors++; $display("FAIL b2b_condexr got=%b exp=0", CondExR); end
      vectors++;
      if (SkipCnt !== 16'd3) begin errors++; $display("FAIL b2b_skip got=%0d exp=3", SkipCnt); end
      idle();
   endtask

   task automatic test_saturate();
      logic [1:0] exp_seq [4];
      exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd3;
      reset2 = 1;
      tick();
      reset2 = 0;
      // dut2 flags are 0000, so EQ fails every time.
      for (int i = 0; i < 4; i++) begin
         fetch(4'h0);
         vectors++;
         if (SkipCnt2 !== exp_seq[i]) begin
            errors++; $display("FAIL sat_skip[%0d] got=%0d exp=%0d", i, SkipCnt2, exp_seq[i]);
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      fetch(4'hE);
      RegW = 1;
      #1;
      vectors++;
      if (RegWrite !== 1'b1) begin errors++; $display("FAIL mid_pre_regwrite got=%b exp=1", RegWrite); end
      #1 reset = 1;
      #1;
      vectors++;
      if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin
         errors++; $display("FAIL mid_enables got=%b exp=000", {PCWrite, RegWrite, MemWrite});
      end
      vectors++;
      if (Flags !== 4'b0000) begin errors++; $display("FAIL mid_flags got=%b exp=0000", Flags); end
      vectors++;
      if (SkipCnt !== 16'd0) begin errors++; $display("FAIL mid_skip got=%0d exp=0", SkipCnt); end
      idle();
      tick();
      reset = 0;
      // First decode after reset sees FLAGS_RST (Z=0): NE passes.
      fetch(4'h1);
      vectors++;
      if (CondExR !== 1'b1) begin errors++; $display("FAIL post_rst_ne got=%b exp=1", CondExR); end
      fetch(4'h0);
      vectors++;
      if (CondExR !== 1'b0 || SkipCnt !== 16'd1) begin
         errors++; $display("FAIL post_rst_eq got=%b/%0d exp=0/1", CondExR, SkipCnt);
      end
   endtask

   initial begin
      test_reset();
      test_always();
      test_cond_fail();
      test_flag_halves();
      test_gt();
      test_same_edge();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
